// File: rtl/tcam_cfg_pkg.sv
// Shared constants, command encodings and FSM states for the TCAM register
// configuration slave.
package tcam_cfg_pkg;

  localparam int LOOK_UP_DATA_WIDTH = 144;
  localparam int ACTION_WIDTH       = 24;
  localparam int REG_ADDR_BUS_WIDTH = 8;
  localparam int REG_DATA_BUS_WIDTH = 16;
  localparam int TCAM_INDEX_WIDTH   = 6;

  localparam int KEY_WORDS = LOOK_UP_DATA_WIDTH / REG_DATA_BUS_WIDTH;
  localparam int ACT_WORDS = 2;
  localparam int FILL_BITS = 2 * KEY_WORDS + ACT_WORDS;

  localparam logic [REG_ADDR_BUS_WIDTH-1:0] ADDR_KEY  = 8'h00;
  localparam logic [REG_ADDR_BUS_WIDTH-1:0] ADDR_MASK = 8'h10;
  localparam logic [REG_ADDR_BUS_WIDTH-1:0] ADDR_ACT  = 8'h20;
  localparam logic [REG_ADDR_BUS_WIDTH-1:0] ADDR_IDX  = 8'h28;
  localparam logic [REG_ADDR_BUS_WIDTH-1:0] ADDR_CMD  = 8'h30;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_INVAL = 3'b001;
  localparam logic [2:0] CMD_CLEAR = 3'b010;

  localparam logic [1:0] TYPE_WRITE = 2'b00;
  localparam logic [1:0] TYPE_INVAL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Offsets rely on 8-bit wrap so addresses below a base fall out of range.
  function automatic logic addr_mapped(input logic [REG_ADDR_BUS_WIDTH-1:0] a);
    logic [REG_ADDR_BUS_WIDTH-1:0] key_off, mask_off, act_off;
    key_off  = a - ADDR_KEY;
    mask_off = a - ADDR_MASK;
    act_off  = a - ADDR_ACT;
    return (key_off < 8'(KEY_WORDS)) || (mask_off < 8'(KEY_WORDS)) ||
           (act_off < 8'(ACT_WORDS)) || (a == ADDR_IDX) || (a == ADDR_CMD);
  endfunction

endpackage

// File: rtl/tcam_stage_regs.sv
// Word-addressed staging registers for key, mask, action and entry index,
// with a per-word filled vector.
module tcam_stage_regs
  import tcam_cfg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [REG_ADDR_BUS_WIDTH-1:0] addr,
  input  logic [REG_DATA_BUS_WIDTH-1:0] din,
  input  logic                          clr_filled,
  input  logic                          idx_inc,
  output logic [LOOK_UP_DATA_WIDTH-1:0] key,
  output logic [LOOK_UP_DATA_WIDTH-1:0] mask,
  output logic [ACTION_WIDTH-1:0]       action,
  output logic [TCAM_INDEX_WIDTH-1:0]   index,
  output logic [FILL_BITS-1:0]          filled
);

  // Clear and write never coincide: clears come from command writes or
  // completions, and staging writes are blocked while a command is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key    <= '0;
      mask   <= '0;
      action <= '0;
      index  <= '0;
      filled <= '0;
    end else begin
      if (clr_filled) filled <= '0;
      if (idx_inc) index <= index + 1'b1;
      for (int k = 0; k < KEY_WORDS; k++) begin
        if (wr_en && addr == ADDR_KEY + 8'(k)) begin
          key[k*REG_DATA_BUS_WIDTH +: REG_DATA_BUS_WIDTH] <= din;
          filled[k] <= 1'b1;
        end
        if (wr_en && addr == ADDR_MASK + 8'(k)) begin
          mask[k*REG_DATA_BUS_WIDTH +: REG_DATA_BUS_WIDTH] <= din;
          filled[KEY_WORDS+k] <= 1'b1;
        end
      end
      if (wr_en && addr == ADDR_ACT) begin
        action[REG_DATA_BUS_WIDTH-1:0] <= din;
        filled[2*KEY_WORDS] <= 1'b1;
      end
      // Only the low byte of the second action word is meaningful.
      if (wr_en && addr == ADDR_ACT + 8'd1) begin
        action[ACTION_WIDTH-1:REG_DATA_BUS_WIDTH] <= din[ACTION_WIDTH-REG_DATA_BUS_WIDTH-1:0];
        filled[2*KEY_WORDS+1] <= 1'b1;
      end
      if (wr_en && addr == ADDR_IDX) index <= din[TCAM_INDEX_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tcam_reg_cfg_if.sv
// Register-bus slave that stages TCAM entry data and issues one entry
// command per command write over a valid/ready handshake.
module tcam_reg_cfg_if
  import tcam_cfg_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_reg_bus_we,
  input  logic [REG_ADDR_BUS_WIDTH-1:0] i_reg_bus_we_addr,
  input  logic [REG_DATA_BUS_WIDTH-1:0] i_reg_bus_we_din,
  input  logic                          i_reg_bus_we_din_v,
  output logic                          o_tcam_busy,
  output logic                          o_tcam_cmd_valid,
  input  logic                          i_tcam_cmd_ready,
  output logic [1:0]                    o_tcam_cmd_type,
  output logic [TCAM_INDEX_WIDTH-1:0]   o_tcam_index,
  output logic [LOOK_UP_DATA_WIDTH-1:0] o_tcam_key,
  output logic [LOOK_UP_DATA_WIDTH-1:0] o_tcam_mask,
  output logic [ACTION_WIDTH-1:0]       o_tcam_action,
  input  logic                          i_tcam_done,
  output logic [15:0]                   o_wr_cnt,
  output logic [15:0]                   o_err_cnt
);

  state_t state, next_state;
  logic [1:0] cmd_type, issue_type;
  logic [FILL_BITS-1:0] filled;
  logic accepted, mapped, is_cmd, stage_we;
  logic issue, err_inc, clr_local, complete, write_done;

  assign accepted   = i_reg_bus_we && i_reg_bus_we_din_v;
  assign mapped     = addr_mapped(i_reg_bus_we_addr);
  assign is_cmd     = i_reg_bus_we_addr == ADDR_CMD;
  assign stage_we   = accepted && (state == ST_IDLE) && !is_cmd;
  assign write_done = complete && (cmd_type == TYPE_WRITE);

  assign o_tcam_busy      = state != ST_IDLE;
  assign o_tcam_cmd_valid = state == ST_ISSUE;
  assign o_tcam_cmd_type  = cmd_type;

  tcam_stage_regs u_stage (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (stage_we),
    .addr       (i_reg_bus_we_addr),
    .din        (i_reg_bus_we_din),
    .clr_filled (clr_local || write_done),
    .idx_inc    (write_done),
    .key        (o_tcam_key),
    .mask       (o_tcam_mask),
    .action     (o_tcam_action),
    .index      (o_tcam_index),
    .filled     (filled)
  );

  // Command decode only happens in IDLE; any mapped access outside IDLE is an error.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    issue_type = TYPE_WRITE;
    err_inc    = 1'b0;
    clr_local  = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accepted && is_cmd) begin
          case (i_reg_bus_we_din[2:0])
            CMD_WRITE: begin
              if (&filled) issue = 1'b1;
              else err_inc = 1'b1;
            end
            CMD_INVAL: begin
              issue      = 1'b1;
              issue_type = TYPE_INVAL;
            end
            CMD_CLEAR: clr_local = 1'b1;
            default:   err_inc = 1'b1;
          endcase
          if (issue) next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_tcam_cmd_ready) begin
          complete   = i_tcam_done;
          next_state = i_tcam_done ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_tcam_done) begin
          complete   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (accepted && mapped && state != ST_IDLE) err_inc = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_type  <= TYPE_WRITE;
      o_wr_cnt  <= '0;
      o_err_cnt <= '0;
    end else begin
      state <= next_state;
      if (issue) cmd_type <= issue_type;
      if (write_done && o_wr_cnt != 16'hFFFF) o_wr_cnt <= o_wr_cnt + 1'b1;
      if (err_inc && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tcam_reg_cfg_if.sv
// Directed-plus-random bench for tcam_reg_cfg_if against a word-level
// reference model of the staging registers, counters and command lifecycle.
module tb_tcam_reg_cfg_if;

  logic         clk = 1'b0;
  logic         rst;
  logic         we, din_v, ready, done;
  logic [7:0]   waddr;
  logic [15:0]  wdin;
  logic         busy, valid;
  logic [1:0]   ctype;
  logic [5:0]   tindex;
  logic [143:0] tkey, tmask;
  logic [23:0]  tact;
  logic [15:0]  wr_cnt, err_cnt;

  int compared, mismatched;

  // Reference model: plain word arrays and per-word fill flags.
  logic [15:0] m_key[9];
  logic [15:0] m_mask[9];
  logic [15:0] m_act[2];
  bit          m_fill[20];
  int          m_index, m_wr, m_err;
  bit          m_busy, m_valid;
  logic [1:0]  m_type;

  always #4 clk = ~clk;

  tcam_reg_cfg_if dut (
    .clk                (clk),
    .rst                (rst),
    .i_reg_bus_we       (we),
    .i_reg_bus_we_addr  (waddr),
    .i_reg_bus_we_din   (wdin),
    .i_reg_bus_we_din_v (din_v),
    .o_tcam_busy        (busy),
    .o_tcam_cmd_valid   (valid),
    .i_tcam_cmd_ready   (ready),
    .o_tcam_cmd_type    (ctype),
    .o_tcam_index       (tindex),
    .o_tcam_key         (tkey),
    .o_tcam_mask        (tmask),
    .o_tcam_action      (tact),
    .i_tcam_done        (done),
    .o_wr_cnt           (wr_cnt),
    .o_err_cnt          (err_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int k = 0; k < 9; k++) begin m_key[k] = '0; m_mask[k] = '0; end
    m_act[0] = '0; m_act[1] = '0;
    for (int k = 0; k < 20; k++) m_fill[k] = 1'b0;
    m_index = 0; m_wr = 0; m_err = 0;
    m_busy = 1'b0; m_valid = 1'b0; m_type = 2'b00;
  endfunction

  function automatic void bumpErr();
    if (m_err < 65535) m_err++;
  endfunction

  function automatic bit allFilled();
    for (int k = 0; k < 20; k++) if (!m_fill[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelWrite(input logic [7:0] addr, input logic [15:0] data);
    int a;
    a = int'(addr);
    if (!(a < 9 || (a >= 16 && a < 25) || a == 32 || a == 33 || a == 40 || a == 48)) return;
    if (m_busy) begin bumpErr(); return; end
    if (a < 9) begin m_key[a] = data; m_fill[a] = 1'b1; end
    else if (a < 25) begin m_mask[a-16] = data; m_fill[a-7] = 1'b1; end
    else if (a < 34) begin m_act[a-32] = data; m_fill[a-14] = 1'b1; end
    else if (a == 40) m_index = int'(data) % 64;
    else begin
      case (int'(data) % 8)
        0: if (allFilled()) begin m_busy = 1'b1; m_valid = 1'b1; m_type = 2'b00; end
           else bumpErr();
        1: begin m_busy = 1'b1; m_valid = 1'b1; m_type = 2'b01; end
        2: for (int k = 0; k < 20; k++) m_fill[k] = 1'b0;
        default: bumpErr();
      endcase
    end
  endfunction

  function automatic void modelComplete();
    if (m_type == 2'b00) begin
      for (int k = 0; k < 20; k++) m_fill[k] = 1'b0;
      m_index = (m_index + 1) % 64;
      if (m_wr < 65535) m_wr++;
    end
    m_busy = 1'b0;
    m_valid = 1'b0;
  endfunction

  function automatic logic [143:0] expKey();
    logic [143:0] v;
    for (int k = 0; k < 9; k++) v[16*k +: 16] = m_key[k];
    return v;
  endfunction

  function automatic logic [143:0] expMask();
    logic [143:0] v;
    for (int k = 0; k < 9; k++) v[16*k +: 16] = m_mask[k];
    return v;
  endfunction

  function automatic logic [7:0] slotAddr(input int w);
    if (w < 9) return 8'(w);
    if (w < 18) return 8'(16 + w - 9);
    return 8'(32 + w - 18);
  endfunction

  function automatic logic [15:0] slotPattern(input int w);
    if (w < 9) return 16'h0011 + 16'(w) * 16'h0100;
    if (w < 18) return 16'hA5A5 ^ 16'(w);
    if (w == 18) return 16'h3456;
    return 16'hAB12;
  endfunction

  function automatic logic [15:0] cmdData(input logic [2:0] c);
    return {13'($urandom), c};
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"},   144'(busy),    144'(m_busy));
    checkOutput({tag, ".valid"},  144'(valid),   144'(m_valid));
    checkOutput({tag, ".type"},   144'(ctype),   144'(m_type));
    checkOutput({tag, ".index"},  144'(tindex),  144'(m_index));
    checkOutput({tag, ".key"},    tkey,          expKey());
    checkOutput({tag, ".mask"},   tmask,         expMask());
    checkOutput({tag, ".action"}, 144'(tact),    144'({m_act[1][7:0], m_act[0]}));
    checkOutput({tag, ".wr_cnt"}, 144'(wr_cnt),  144'(m_wr));
    checkOutput({tag, ".err_cnt"},144'(err_cnt), 144'(m_err));
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data);
    we = 1'b1; din_v = 1'b1; waddr = addr; wdin = data;
    tick();
    we = 1'b0; din_v = 1'b0;
    modelWrite(addr, data);
  endtask

  // Writes all 20 staging words in shuffled order, optionally leaving one out.
  task automatic writeAll(input int skip, input bit directed);
    int order[20];
    int j, t, w;
    for (int s = 0; s < 20; s++) order[s] = s;
    for (int s = 19; s > 0; s--) begin
      j = int'($urandom_range(s, 0));
      t = order[s]; order[s] = order[j]; order[j] = t;
    end
    for (int s = 0; s < 20; s++) begin
      w = order[s];
      if (w != skip) applyStimulus(slotAddr(w), directed ? slotPattern(w) : 16'($urandom));
    end
  endtask

  // Entered one sample after the issuing command edge; ready is held low for
  // ready_wait cycles, done follows done_after cycles after ready (0 = same cycle).
  task automatic handshake(input string tag, input int ready_wait, input int done_after, input bit poke_wait);
    int busy_seen, valid_seen, unstable;
    logic [319:0] snap;
    logic [7:0] pa;
    logic [15:0] pd;
    busy_seen = 0; valid_seen = 0; unstable = 0;
    checkAll({tag, ".issue"});
    snap = {ctype, tindex, tkey, tmask, tact};
    for (int i = 0; i <= ready_wait; i++) begin
      if (busy === 1'b1) busy_seen++;
      if (valid === 1'b1) valid_seen++;
      if ({ctype, tindex, tkey, tmask, tact} !== snap) unstable++;
      if (i == ready_wait) begin
        ready = 1'b1;
        if (done_after == 0) done = 1'b1;
      end
      tick();
    end
    ready = 1'b0; done = 1'b0;
    m_valid = 1'b0;
    for (int j = 1; j <= done_after; j++) begin
      if (busy === 1'b1) busy_seen++;
      if (valid === 1'b1) valid_seen++;
      if (poke_wait && j == 1) begin
        pa = 8'($urandom_range(8, 0)); pd = 16'($urandom);
        we = 1'b1; din_v = 1'b1; waddr = pa; wdin = pd;
      end
      if (j == done_after) done = 1'b1;
      tick();
      we = 1'b0; din_v = 1'b0; done = 1'b0;
      if (poke_wait && j == 1) modelWrite(pa, pd);
    end
    modelComplete();
    if (busy === 1'b1) busy_seen++;
    if (valid === 1'b1) valid_seen++;
    checkOutput({tag, ".busy_cycles"}, 144'(busy_seen), 144'(ready_wait + done_after + 1));
    checkOutput({tag, ".valid_cycles"}, 144'(valid_seen), 144'(ready_wait + 1));
    checkOutput({tag, ".cmd_stable"}, 144'(unstable), 144'(0));
    checkAll({tag, ".done"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [143:0] saved_key;
    compared = 0; mismatched = 0;
    rst = 1'b1; we = 1'b0; din_v = 1'b0; waddr = '0; wdin = '0; ready = 1'b0; done = 1'b0;
    modelReset();
    tick(); tick();
    checkAll("reset");
    rst = 1'b0;
    tick();

    $display("[TB] strobe qualification and idle done");
    we = 1'b1; din_v = 1'b0; waddr = 8'h00; wdin = 16'hBEEF; tick();
    we = 1'b0; din_v = 1'b1; tick();
    din_v = 1'b0; done = 1'b1; tick(); done = 1'b0;
    checkAll("qual");

    $display("[TB] directed full write");
    writeAll(-1, 1'b1);
    applyStimulus(8'h30, cmdData(3'b000));
    checkOutput("t1.index0", 144'(tindex), 144'(0));
    handshake("t1", 0, 3, 1'b0);
    checkOutput("t1.action_const", 144'(tact), 144'(24'h123456));
    checkOutput("t1.wr1", 144'(wr_cnt), 144'(1));
    checkOutput("t1.index1", 144'(tindex), 144'(1));

    $display("[TB] partial staging rejected");
    writeAll(int'($urandom_range(19, 0)), 1'b0);
    applyStimulus(8'h30, cmdData(3'b000));
    checkAll("t2");
    checkOutput("t2.err1", 144'(err_cnt), 144'(1));
    checkOutput("t2.busy0", 144'(busy), 144'(0));

    $display("[TB] ready held low");
    writeAll(-1, 1'b0);
    applyStimulus(8'h30, cmdData(3'b000));
    handshake("t3", 5, int'($urandom_range(4, 1)), 1'b0);

    $display("[TB] index wrap with write during wait");
    applyStimulus(8'h28, {10'($urandom), 6'h3F});
    writeAll(-1, 1'b0);
    saved_key = expKey();
    applyStimulus(8'h30, cmdData(3'b000));
    handshake("t4", int'($urandom_range(2, 0)), int'($urandom_range(5, 2)), 1'b1);
    checkOutput("t4.wrap", 144'(tindex), 144'(0));
    checkOutput("t4.key_kept", tkey, saved_key);

    $display("[TB] invalidate keeps staging");
    writeAll(-1, 1'b0);
    applyStimulus(8'h28, 16'h0005);
    applyStimulus(8'h30, cmdData(3'b001));
    handshake("t5", int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1'b0);
    checkOutput("t5.index5", 144'(tindex), 144'(5));
    applyStimulus(8'h30, cmdData(3'b000));
    handshake("t5w", 0, 0, 1'b0);

    $display("[TB] clear, bad commands, unmapped");
    writeAll(-1, 1'b0);
    applyStimulus(8'h30, cmdData(3'b010));
    applyStimulus(8'h30, cmdData(3'b000));
    for (int c = 3; c < 8; c++) applyStimulus(8'h30, cmdData(3'(c)));
    applyStimulus(8'h09, 16'($urandom));
    applyStimulus(8'h22, 16'($urandom));
    applyStimulus(8'hFF, 16'($urandom));
    checkAll("t6");

    $display("[TB] random commands");
    for (int it = 0; it < 4; it++) begin
      writeAll(-1, 1'b0);
      if ($urandom_range(1, 0) == 1) applyStimulus(8'h28, 16'($urandom));
      applyStimulus(8'h30, cmdData(3'($urandom_range(1, 0))));
      handshake($sformatf("t7_%0d", it), int'($urandom_range(3, 0)), int'($urandom_range(4, 0)), 1'b0);
    end

    $display("[TB] reset during issue");
    writeAll(-1, 1'b0);
    applyStimulus(8'h30, cmdData(3'b000));
    checkOutput("t8.valid_pre", 144'(valid), 144'(1));
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll("t8.async");
    #1 rst = 1'b0;
    writeAll(-1, 1'b0);
    applyStimulus(8'h30, cmdData(3'b000));
    checkOutput("t8.index0", 144'(tindex), 144'(0));
    handshake("t8", int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
